// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: raster mode constants, axis phase type and address width
package vga_timing_pkg;
  localparam int ADDR_W = 12;
  typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_t;
  localparam int M800_H_SYNC = 128;
  localparam int M800_H_BACK = 88;
  localparam int M800_H_ACTIVE = 800;
  localparam int M800_H_FRONT = 40;
  localparam int M800_V_SYNC = 4;
  localparam int M800_V_BACK = 23;
  localparam int M800_V_ACTIVE = 600;
  localparam int M800_V_FRONT = 1;
  localparam bit M800_H_POL = 1'b1;
  localparam bit M800_V_POL = 1'b1;
  localparam int M640_H_SYNC = 96;
  localparam int M640_H_BACK = 48;
  localparam int M640_H_ACTIVE = 640;
  localparam int M640_H_FRONT = 16;
  localparam int M640_V_SYNC = 2;
  localparam int M640_V_BACK = 33;
  localparam int M640_V_ACTIVE = 480;
  localparam int M640_V_FRONT = 10;
  localparam bit M640_H_POL = 1'b0;
  localparam bit M640_V_POL = 1'b0;
endpackage

// File: rtl/vga_timing_axis.sv
// vga_timing_axis: one raster axis counter with its SYNC/BACK/ACTIVE/FRONT phase FSM
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int SYNC = M800_H_SYNC,
  parameter int BACK = M800_H_BACK,
  parameter int ACTIVE = M800_H_ACTIVE,
  parameter int FRONT = M800_H_FRONT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output phase_t            phase,
  output logic              wrap
);
  localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] END_SYNC = ADDR_W'(SYNC - 1);
  localparam logic [ADDR_W-1:0] END_BACK = ADDR_W'(SYNC + BACK - 1);
  localparam logic [ADDR_W-1:0] END_ACT = ADDR_W'(SYNC + BACK + ACTIVE - 1);
  if (TOTAL > 4096) begin : g_total_chk
    $error("vga_timing_axis: total %0d exceeds 4096", TOTAL);
  end
  phase_t phase_nxt;
  assign wrap = cnt == LAST;
  // phase transitions track the counter edges, so the FSM never drifts from cnt
  always_comb
    phase_nxt = !en               ? phase     :
                wrap              ? PH_SYNC   :
                cnt == END_SYNC   ? PH_BACK   :
                cnt == END_BACK   ? PH_ACTIVE :
                cnt == END_ACT    ? PH_FRONT  : phase;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      phase <= PH_SYNC;
    end else begin
      phase <= phase_nxt;
      if (en) cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator driving sync pins and pixel address/ready/frame outputs
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC = M800_H_SYNC,
  parameter int H_BACK = M800_H_BACK,
  parameter int H_ACTIVE = M800_H_ACTIVE,
  parameter int H_FRONT = M800_H_FRONT,
  parameter int V_SYNC = M800_V_SYNC,
  parameter int V_BACK = M800_V_BACK,
  parameter int V_ACTIVE = M800_V_ACTIVE,
  parameter int V_FRONT = M800_V_FRONT,
  parameter bit H_POL = M800_H_POL,
  parameter bit V_POL = M800_V_POL
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              en,
  output logic              HSYNC_Sig,
  output logic              VSYNC_Sig,
  output logic              Ready_Sig,
  output logic [ADDR_W-1:0] Column_Addr_Sig,
  output logic [ADDR_W-1:0] Row_Addr_Sig,
  output logic              Frame_Sig
);
  localparam logic [ADDR_W-1:0] H_OFS = ADDR_W'(H_SYNC + H_BACK);
  localparam logic [ADDR_W-1:0] V_OFS = ADDR_W'(V_SYNC + V_BACK);
  logic [ADDR_W-1:0] h_cnt, v_cnt;
  phase_t h_ph, v_ph;
  logic h_wrap, v_wrap, vis;
  vga_timing_axis #(.SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)) u_h (
    .clk(vga_clk), .rst(rst), .en(en), .cnt(h_cnt), .phase(h_ph), .wrap(h_wrap)
  );
  vga_timing_axis #(.SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)) u_v (
    .clk(vga_clk), .rst(rst), .en(en & h_wrap), .cnt(v_cnt), .phase(v_ph), .wrap(v_wrap)
  );
  assign vis = (h_ph == PH_ACTIVE) & (v_ph == PH_ACTIVE);
  // Frame is the only output not held while en is low, so a pulse is never seen twice
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      HSYNC_Sig <= ~H_POL;
      VSYNC_Sig <= ~V_POL;
      Ready_Sig <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig <= '0;
      Frame_Sig <= 1'b0;
    end else if (en) begin
      HSYNC_Sig <= H_POL ^ (h_ph != PH_SYNC);
      VSYNC_Sig <= V_POL ^ (v_ph != PH_SYNC);
      Ready_Sig <= vis;
      Column_Addr_Sig <= vis ? h_cnt - H_OFS : '0;
      Row_Addr_Sig <= vis ? v_cnt - V_OFS : '0;
      Frame_Sig <= h_wrap & v_wrap;
    end else begin
      Frame_Sig <= 1'b0;
    end
  end
endmodule
